rggen_round_robin_arbiter: RTL and testbench

RGGEN_ROUND_ROBIN_ARBITER -- requirements
Module: rggen_round_robin_arbiter

---
 rtl/rggen_round_robin_arbiter.sv | 140 ++++++++++++++
 tb/tb_rggen_round_robin_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rggen_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_round_robin_arbiter
//
// Round-robin arbiter that shares one downstream register-access path among
// N requesters. A grant is held until the owner signals completion with
// i_done; at that point the priority pointer moves past the finished owner
// and a new winner is picked in the same cycle (back-to-back grants).
//
// Ports
//   i_clk      : clock, all state changes on the rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_request  : [N-1:0] level requests, bit k = requester k
//   i_done     : one-cycle pulse, current granted access has completed
//   o_grant    : [N-1:0] registered one-hot grant
//   o_busy     : registered, high whenever a grant is outstanding
// ---------------------------------------------------------------------------
module rggen_round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_request,
  input  logic         i_done,
  output logic [N-1:0] o_grant,
  output logic         o_busy
);

  // Index width; at least one bit so N=1 still has legal vectors.
  localparam int            PW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]   N_W = (PW + 1)'(N);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t         state_reg;
  logic [PW-1:0]  ptr_reg;
  logic [PW-1:0]  ptr_next;
  logic [PW-1:0]  win_reg;
  logic [PW-1:0]  win_next;
  logic [N-1:0]   grant_reg;
  logic           busy_reg;
  logic [N-1:0]   win_onehot;
  logic [N-1:0]   req_rot;
  logic [PW-1:0]  rot_idx [N];
  logic           any_req;

  assign any_req = |i_request;

  // The pointer that arbitration uses this cycle. When the current owner
  // finishes, arbitration already runs against the advanced pointer so the
  // finishing requester drops to lowest priority.
  always_comb begin
    ptr_next = ptr_reg;
    if ((state_reg == BUSY) && i_done) begin
      if (int'(win_reg) >= (N - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = win_reg + 1'b1;
      end
    end
  end

  // Rotate the request vector so that offset 0 is the highest-priority
  // requester; rot_idx maps each offset back to its real requester index.
  generate
    if (N == 1) begin : g_single
      assign rot_idx[0] = '0;
      assign req_rot[0] = i_request[0];
    end else begin : g_multi
      for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [PW:0] sum;
        assign sum         = {1'b0, ptr_next} + (PW + 1)'(gi);
        assign rot_idx[gi] = (sum >= N_W) ? PW'(sum - N_W) : sum[PW-1:0];
        assign req_rot[gi] = i_request[rot_idx[gi]];
      end
    end
  endgenerate

  // Lowest rotated offset wins; scanning downward lets the last hit stand.
  always_comb begin
    win_next = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_next = rot_idx[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_next == PW'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // i_done is meaningless here; nothing to release.
          if (any_req) begin
            state_reg <= BUSY;
            win_reg   <= win_next;
            grant_reg <= win_onehot;
            busy_reg  <= 1'b1;
          end
        end
        BUSY: begin
          if (i_done) begin
            ptr_reg <= ptr_next;
            if (any_req) begin
              win_reg   <= win_next;
              grant_reg <= win_onehot;
            end else begin
              state_reg <= IDLE;
              grant_reg <= '0;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant = grant_reg;
  assign o_busy  = busy_reg;

endmodule

// File: tb/tb_rggen_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rggen_round_robin_arbiter
//
// Directed bench for the round-robin arbiter: one N=4 instance and one N=1
// instance sharing clock and reset. Inputs change on the falling edge and
// outputs are checked on the falling edge, after the rising edge settled.
// ---------------------------------------------------------------------------
module tb_rggen_round_robin_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req4;
  logic       done4;
  logic [3:0] grant4;
  logic       busy4;
  logic [0:0] req1;
  logic       done1;
  logic [0:0] grant1;
  logic       busy1;

  int vectors;
  int errors;

  rggen_round_robin_arbiter #(.N(4)) u_dut4 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_request (req4),
    .i_done    (done4),
    .o_grant   (grant4),
    .o_busy    (busy4)
  );

  rggen_round_robin_arbiter #(.N(1)) u_dut1 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_request (req1),
    .i_done    (done1),
    .o_grant   (grant1),
    .o_busy    (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk4(input string tag, input logic [3:0] eg, input logic eb);
    vectors++;
    assert (grant4 === eg) else begin
      errors++;
      $error("FAIL %s grant observed=%b expected=%b", tag, grant4, eg);
    end
    vectors++;
    assert (busy4 === eb) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy4, eb);
    end
    $display("[%0t] %s grant=%b busy=%b", $time, tag, grant4, busy4);
  endtask

  task automatic chk1(input string tag, input logic eg, input logic eb);
    vectors++;
    assert (grant1 === eg) else begin
      errors++;
      $error("FAIL %s grant observed=%b expected=%b", tag, grant1, eg);
    end
    vectors++;
    assert (busy1 === eb) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy1, eb);
    end
    $display("[%0t] %s grant=%b busy=%b", $time, tag, grant1, busy1);
  endtask

  // One clock: the rising edge happens in between, we land on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Request pattern presented in the done cycle, then done drops.
  task automatic done4_with(input logic [3:0] r);
    req4  = r;
    done4 = 1'b1;
    tick();
    done4 = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req4    = 4'b0000;
    done4   = 1'b0;
    req1    = 1'b0;
    done1   = 1'b0;

    #3;
    chk4("reset_state", 4'b0000, 1'b0);
    chk1("reset_state_n1", 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // First grant from P=0 picks requester 1; request changes are ignored while busy.
    req4 = 4'b0110;
    tick();
    chk4("first_grant_0110", 4'b0010, 1'b1);
    req4 = 4'b1001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk4("hold_no_done", 4'b0010, 1'b1);
    end

    // Done with nothing requested -> IDLE, pointer now 2.
    done4_with(4'b0000);
    chk4("done_to_idle", 4'b0000, 1'b0);
    done4_with(4'b0000);
    chk4("done_in_idle_1", 4'b0000, 1'b0);
    done4_with(4'b0000);
    chk4("done_in_idle_2", 4'b0000, 1'b0);

    // Pointer 2 after the earlier done, so all-request grants requester 2.
    req4 = 4'b1111;
    tick();
    chk4("grant_from_p2", 4'b0100, 1'b1);

    // Owner alone keeps the path; with a competitor it loses.
    done4_with(4'b0100);
    chk4("sole_requester_regrant", 4'b0100, 1'b1);
    done4_with(4'b0110);
    chk4("owner_lowest_priority", 4'b0010, 1'b1);

    // Walk around, including the wrap from 3 to 0.
    done4_with(4'b1111);
    chk4("rr_to_2", 4'b0100, 1'b1);
    done4_with(4'b1111);
    chk4("rr_to_3", 4'b1000, 1'b1);
    done4_with(4'b1001);
    chk4("wrap_1001", 4'b0001, 1'b1);
    done4_with(4'b0000);
    chk4("wrap_then_idle", 4'b0000, 1'b0);
    done4_with(4'b0000);
    chk4("idle_done_ignored", 4'b0000, 1'b0);

    // Pointer is 1 now: all-request grants requester 1.
    req4 = 4'b1111;
    tick();
    chk4("grant_from_p1", 4'b0010, 1'b1);

    // Fresh reset, then the full rotation with back-to-back grants.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req4  = 4'b1111;
    tick();
    chk4("seq_0001", 4'b0001, 1'b1);
    done4_with(4'b1111);
    chk4("seq_0010", 4'b0010, 1'b1);
    done4_with(4'b1111);
    chk4("seq_0100", 4'b0100, 1'b1);
    done4_with(4'b1111);
    chk4("seq_1000", 4'b1000, 1'b1);
    done4_with(4'b1111);
    chk4("seq_0001_again", 4'b0001, 1'b1);

    // Get grant 0100 (pointer 1), then reset asynchronously between edges.
    done4_with(4'b0100);
    chk4("pre_async_grant", 4'b0100, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_reset_drop", 4'b0000, 1'b0);
    req4 = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    // Pointer must be back to 0, otherwise requester 3 would win.
    req4 = 4'b1001;
    tick();
    chk4("post_reset_1001", 4'b0001, 1'b1);

    // N=1: continuous grant with periodic done while requesting.
    req1 = 1'b1;
    tick();
    chk1("n1_first_grant", 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      done1 = (i % 3 == 0);
      tick();
      done1 = 1'b0;
      chk1("n1_continuous", 1'b1, 1'b1);
    end
    req1  = 1'b0;
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    chk1("n1_release", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
